// File: rtl/term.sv
// LED animation engine: synchronised buttons set the speed level, the switches pick the
// pattern, and an IR pause line freezes stepping. Seven-segment status digits are active-low.
module term #(
  parameter int unsigned TICK_DIV = 5_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       up,
  input  logic       down,
  input  logic       sw1,
  input  logic       sw2,
  input  logic       sw3,
  input  logic       IRDA,
  output logic [9:0] led,
  output logic [6:0] hex0,
  output logic [6:0] hex1,
  output logic [6:0] hex2,
  output logic [6:0] hex3,
  output logic [6:0] hex4,
  output logic [6:0] hex5
);

  localparam int unsigned CW = $clog2(TICK_DIV * 8 + 1);

  typedef enum logic [1:0] {
    M_OFF    = 2'd0,
    M_RUN    = 2'd1,
    M_BOUNCE = 2'd2,
    M_FILL   = 2'd3
  } mode_e;

  logic          up_meta_q, up_sync_q, up_hist_q;
  logic          dn_meta_q, dn_sync_q, dn_hist_q;
  logic          ir_meta_q, ir_sync_q;
  logic [3:0]    level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [4:0]    pos_q, pos_d;
  mode_e         mode, mode_prev_q;

  logic          up_ev, dn_ev, paused;
  logic [CW-1:0] period;
  logic [4:0]    pos_last;

  always_comb begin
    if (sw1)      mode = M_RUN;
    else if (sw2) mode = M_BOUNCE;
    else if (sw3) mode = M_FILL;
    else          mode = M_OFF;
  end

  assign up_ev  = up_hist_q & ~up_sync_q;
  assign dn_ev  = dn_hist_q & ~dn_sync_q;
  assign paused = ~ir_sync_q;
  assign period = CW'(TICK_DIV * (32'd9 - 32'(level_q)));

  always_comb begin
    case (mode)
      M_RUN:    pos_last = 5'd9;
      M_BOUNCE: pos_last = 5'd17;
      M_FILL:   pos_last = 5'd10;
      default:  pos_last = 5'd0;
    endcase
  end

  always_comb begin
    level_d = level_q;
    if (up_ev && !dn_ev && level_q != 4'd8)
      level_d = level_q + 4'd1;
    else if (dn_ev && !up_ev && level_q != 4'd1)
      level_d = level_q - 4'd1;
  end

  // Mode is decoded straight from the switches so the display is valid during reset;
  // mode_prev_q only exists to spot a switch change and restart the pattern.
  always_comb begin
    cnt_d = cnt_q;
    pos_d = pos_q;
    if (mode != mode_prev_q || mode == M_OFF) begin
      cnt_d = '0;
      pos_d = '0;
    end else if (level_d != level_q) begin
      cnt_d = '0;
    end else if (!paused) begin
      if (cnt_q == period - CW'(1)) begin
        cnt_d = '0;
        pos_d = (pos_q == pos_last) ? 5'd0 : pos_q + 5'd1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      up_meta_q   <= 1'b1;
      up_sync_q   <= 1'b1;
      up_hist_q   <= 1'b1;
      dn_meta_q   <= 1'b1;
      dn_sync_q   <= 1'b1;
      dn_hist_q   <= 1'b1;
      ir_meta_q   <= 1'b1;
      ir_sync_q   <= 1'b1;
      level_q     <= 4'd4;
      cnt_q       <= '0;
      pos_q       <= '0;
      mode_prev_q <= M_OFF;
    end else begin
      up_meta_q   <= up;
      up_sync_q   <= up_meta_q;
      up_hist_q   <= up_sync_q;
      dn_meta_q   <= down;
      dn_sync_q   <= dn_meta_q;
      dn_hist_q   <= dn_sync_q;
      ir_meta_q   <= IRDA;
      ir_sync_q   <= ir_meta_q;
      level_q     <= level_d;
      cnt_q       <= cnt_d;
      pos_q       <= pos_d;
      mode_prev_q <= mode;
    end
  end

  logic [10:0] one_hot;
  assign one_hot = 11'd1 << pos_q;

  always_comb begin
    led = '0;
    case (mode)
      M_RUN:    led = one_hot[9:0];
      M_BOUNCE: led = (pos_q <= 5'd9) ? one_hot[9:0] : (10'd1 << (5'd18 - pos_q));
      M_FILL:   led = 10'(one_hot - 11'd1);
      default:  led = '0;
    endcase
  end

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h40;
      4'd1:    seg7 = 7'h79;
      4'd2:    seg7 = 7'h24;
      4'd3:    seg7 = 7'h30;
      4'd4:    seg7 = 7'h19;
      4'd5:    seg7 = 7'h12;
      4'd6:    seg7 = 7'h02;
      4'd7:    seg7 = 7'h78;
      4'd8:    seg7 = 7'h00;
      4'd9:    seg7 = 7'h10;
      default: seg7 = 7'h7F;
    endcase
  endfunction

  logic [4:0] pos_mod10;
  assign pos_mod10 = (pos_q >= 5'd10) ? pos_q - 5'd10 : pos_q;

  assign hex0 = seg7(level_q);
  assign hex1 = 7'h7F;
  assign hex2 = seg7({2'b00, mode});
  assign hex3 = 7'h7F;
  assign hex4 = seg7(pos_mod10[3:0]);
  assign hex5 = paused ? 7'h0C : 7'h7F;

endmodule

// File: tb/tb_term.sv
// Directed bench for term with TICK_DIV=10: speed control, the three patterns,
// mode switching, pause and asynchronous reset.
module tb_term;

  logic       clk = 1'b0;
  logic       reset, up, down, sw1, sw2, sw3, IRDA;
  logic [9:0] led;
  logic [6:0] hex0, hex1, hex2, hex3, hex4, hex5;

  int n_cmp  = 0;
  int n_fail = 0;

  localparam logic [9:0] RUN [10] = '{10'h001, 10'h002, 10'h004, 10'h008, 10'h010,
                                      10'h020, 10'h040, 10'h080, 10'h100, 10'h200};
  localparam logic [9:0] BNC [18] = '{10'h001, 10'h002, 10'h004, 10'h008, 10'h010,
                                      10'h020, 10'h040, 10'h080, 10'h100, 10'h200,
                                      10'h100, 10'h080, 10'h040, 10'h020, 10'h010,
                                      10'h008, 10'h004, 10'h002};
  localparam logic [9:0] FIL [11] = '{10'h000, 10'h001, 10'h003, 10'h007, 10'h00F,
                                      10'h01F, 10'h03F, 10'h07F, 10'h0FF, 10'h1FF,
                                      10'h3FF};
  localparam logic [9:0] SEG [10] = '{10'h40, 10'h79, 10'h24, 10'h30, 10'h19,
                                      10'h12, 10'h02, 10'h78, 10'h00, 10'h10};

  term #(.TICK_DIV(10)) dut (
    .clk  (clk),
    .reset(reset),
    .up   (up),
    .down (down),
    .sw1  (sw1),
    .sw2  (sw2),
    .sw3  (sw3),
    .IRDA (IRDA),
    .led  (led),
    .hex0 (hex0),
    .hex1 (hex1),
    .hex2 (hex2),
    .hex3 (hex3),
    .hex4 (hex4),
    .hex5 (hex5)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %03h expected %03h", tag, obs, exp);
    end
  endtask

  task automatic press_up();
    up = 1'b0; step(5);
    up = 1'b1; step(5);
  endtask

  task automatic press_down();
    down = 1'b0; step(5);
    down = 1'b1; step(5);
  endtask

  localparam logic [9:0] UP_LVL [6] = '{10'h12, 10'h02, 10'h78, 10'h00, 10'h00, 10'h00};
  localparam logic [9:0] DN_LVL [6] = '{10'h12, 10'h19, 10'h30, 10'h24, 10'h79, 10'h79};

  initial begin
    reset = 1'b1; up = 1'b1; down = 1'b1;
    sw1 = 1'b1; sw2 = 1'b0; sw3 = 1'b0; IRDA = 1'b1;
    #2 reset = 1'b0;
    step(2);
    chk("rst_led",  led, 10'h001);
    chk("rst_hex0", 10'(hex0), 10'h19);
    chk("rst_hex1", 10'(hex1), 10'h7F);
    chk("rst_hex2", 10'(hex2), 10'h79);
    chk("rst_hex3", 10'(hex3), 10'h7F);
    chk("rst_hex4", 10'(hex4), 10'h40);
    chk("rst_hex5", 10'(hex5), 10'h7F);
    reset = 1'b1;

    for (int i = 0; i < 6; i++) begin
      press_up();
      chk($sformatf("up_lvl%0d", i), 10'(hex0), UP_LVL[i]);
    end

    sw1 = 1'b0; step(2);
    chk("off_led",  led, 10'h000);
    chk("off_hex2", 10'(hex2), 10'h40);
    sw1 = 1'b1; step(1);
    chk("run_start", led, 10'h001);
    for (int k = 1; k <= 10; k++) begin
      step(9);
      chk($sformatf("run_hold%0d", k), led, RUN[(k - 1) % 10]);
      step(1);
      chk($sformatf("run_step%0d", k), led, RUN[k % 10]);
    end

    press_down();
    chk("dn_lvl7", 10'(hex0), 10'h78);
    press_down();
    chk("dn_lvl6", 10'(hex0), 10'h02);
    sw1 = 1'b0; step(2);
    sw1 = 1'b1; step(1);
    step(29);
    chk("p30_hold", led, 10'h001);
    step(1);
    chk("p30_step", led, 10'h002);

    sw1 = 1'b0; sw2 = 1'b1; step(1);
    chk("bnc_start", led, 10'h001);
    chk("bnc_hex2",  10'(hex2), 10'h24);
    for (int k = 1; k <= 19; k++) begin
      step(30);
      chk($sformatf("bnc_led%0d", k), led, BNC[k % 18]);
      chk($sformatf("bnc_hex4_%0d", k), 10'(hex4), SEG[(k % 18) % 10]);
    end

    sw2 = 1'b0; sw3 = 1'b1; step(1);
    chk("fil_start", led, 10'h000);
    chk("fil_hex2",  10'(hex2), 10'h30);
    for (int k = 1; k <= 13; k++) begin
      step(30);
      chk($sformatf("fil_led%0d", k), led, FIL[k % 11]);
    end
    step(10);
    sw1 = 1'b1; step(1);
    chk("sw1_led",  led, 10'h001);
    chk("sw1_hex2", 10'(hex2), 10'h79);
    chk("sw1_hex4", 10'(hex4), 10'h40);
    step(30);
    chk("sw1_step", led, 10'h002);

    IRDA = 1'b0; step(2);
    chk("pause_hex5", 10'(hex5), 10'h0C);
    step(98);
    chk("pause_led",  led, 10'h002);
    chk("pause_hex5b", 10'(hex5), 10'h0C);
    IRDA = 1'b1; step(2);
    chk("resume_hex5", 10'(hex5), 10'h7F);
    step(27);
    chk("resume_hold", led, 10'h002);
    step(1);
    chk("resume_step", led, 10'h004);

    up = 1'b0; down = 1'b0; step(5);
    up = 1'b1; down = 1'b1; step(5);
    chk("both_lvl", 10'(hex0), 10'h02);

    for (int i = 0; i < 6; i++) begin
      press_down();
      chk($sformatf("dn_sat%0d", i), 10'(hex0), DN_LVL[i]);
    end

    step(15);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_led",  led, 10'h001);
    chk("mid_rst_hex0", 10'(hex0), 10'h19);
    chk("mid_rst_hex4", 10'(hex4), 10'h40);
    chk("mid_rst_hex5", 10'(hex5), 10'h7F);
    step(1);
    reset = 1'b1;
    step(45);
    chk("post_rst_hold", led, 10'h001);
    step(10);
    chk("post_rst_step", led, 10'h002);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/term.md
TERM -- requirements
Module: term

Interface
REQ-001 Parameter TICK_DIV, default 5_000_000, base step period in clk cycles (0.1 s at 50 MHz).
REQ-002 clk  input  1  system clock, 50 MHz, all logic on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 up  input  1  speed-up push button, active-low, asynchronous to clk.
REQ-005 down  input  1  speed-down push button, active-low, asynchronous to clk.
REQ-006 sw1, sw2, sw3  input  1 each  pattern select switches, active-high.
REQ-007 IRDA  input  1  IR receiver line, idle high; low means pause.
REQ-008 led  output  10  LED bar, active-high.
REQ-009 hex0..hex5  output  7 each  seven-segment digits, active-low, bit0=a ... bit6=g.

Function
REQ-010 up, down and IRDA SHALL each pass through a 2-flop synchronizer before use.
REQ-011 A speed event SHALL occur on a synchronized high-to-low transition (press) of up or down, once per press.
REQ-012 Speed level SHALL be a 1..8 register.
REQ-013 An up press SHALL increment the level, saturating at 8.
REQ-014 A down press SHALL decrement the level, saturating at 1.
REQ-015 Simultaneous up and down press events in the same cycle SHALL leave the level unchanged.
REQ-016 Step period SHALL be TICK_DIV*(9-level) cycles; a 1-cycle step tick is issued when the tick counter reaches period-1, then the counter clears.
REQ-017 A level change SHALL clear the tick counter in the same cycle.
REQ-018 While synchronized IRDA=0 (paused), the tick counter and pattern position SHALL hold.
REQ-019 Mode SHALL be decoded with priority sw1 > sw2 > sw3.
REQ-020 Mode decode: sw1=1 gives mode 1; else sw2=1 gives mode 2; else sw3=1 gives mode 3; else mode 0.
REQ-021 Mode 1 (run): position 0..9 wrapping 9->0; led = 1<<pos.
REQ-022 Mode 2 (bounce): position 0..17 wrapping 17->0; led = 1<<pos for pos<=9, else 1<<(18-pos).
REQ-023 Mode 3 (fill): position 0..10 wrapping 10->0; led = (1<<pos)-1, giving 0 LEDs through 10 LEDs lit.
REQ-024 Mode 0: led = 0; position and tick counter held at 0.
REQ-025 Each step tick SHALL advance the position by 1 with the mode's wrap rule.
REQ-026 Any change of mode SHALL reset the position and tick counter to 0 in the same cycle.
REQ-027 led SHALL be decoded combinationally from the mode and position registers.
REQ-028 Segment codes: 0=40h, 1=79h, 2=24h, 3=30h, 4=19h, 5=12h, 6=02h, 7=78h, 8=00h, 9=10h, blank=7Fh, P=0Ch.
REQ-029 hex0 SHALL show the speed level digit.
REQ-030 hex1 and hex3 SHALL be blank.
REQ-031 hex2 SHALL show the mode digit 0..3.
REQ-032 hex4 SHALL show position mod 10.
REQ-033 hex5 SHALL show P while paused, else blank.
REQ-034 All hex outputs SHALL be combinational from registered state.

Reset
REQ-035 While reset=0, the following SHALL hold: level=4, position=0, tick counter=0, edge-detect history=1 (released), synchronizers=1.
REQ-036 Reset values SHALL take effect asynchronously.
REQ-037 Output values during reset with sw1=1 and IRDA=1: led=001h, hex0=19h, hex2=79h, hex4=40h, hex5=7Fh.
REQ-038 Reset asserted mid-animation SHALL abort the animation immediately.
REQ-039 After reset release, operation SHALL resume from position 0 at level 4.

Verification
REQ-040 Verification SHALL use TICK_DIV=10 and cover the scenarios below.
REQ-041 Scenario 1: reset pulse with sw1=1 -> led=001h, hex0 shows 4.
REQ-042 Scenario 2: six up presses of 5 cycles low, 5 cycles high -> level 5,6,7,8,8,8 and hex0=00h; then led shifts one LED left every 10 cycles, 9->0 wrap giving 200h then 001h.
REQ-043 Scenario 3: from level 8, two down presses -> level 6, step period 30 cycles.
REQ-044 Scenario 4: sw2 only -> led walks 001h up to 200h, then 100h back down to 001h, repeating with period 18 steps.
REQ-045 Scenario 5: sw3 only -> led 000h, 001h, 003h ... 3FFh, then 000h; set sw1 mid-sequence -> position 0, led=001h next cycle.
REQ-046 Scenario 6: hold IRDA=0 -> led frozen and hex5=0Ch; release -> stepping resumes from the held position; up and down pressed together -> level unchanged.
